nested_loop_engine: RTL and testbench
=====================================

NESTED_LOOP_ENGINE -- requirements
Module: nested_loop_engine

Interface
REQ-001 WIDTH SHALL default to 16 and set the bit width of each operand and of each result.
REQ-002 OUTER_N SHALL default to 105 and set the outer loop trip count; 0 is legal.
REQ-003 INNER_N SHALL default to 101 and set the inner loop trip count; 0 is legal.
REQ-004 clk SHALL be a 1-bit input and the single clock; all state updates on its rising edge.
REQ-005 rst SHALL be a 1-bit input; reset is asynchronous and active-low.
REQ-006 a, b, c, d SHALL be WIDTH-bit inputs carrying the operands (a is the outer start, b/c/d are masks).
REQ-007 start SHALL be a 1-bit input, level-sensitive run request.
REQ-008 g, h SHALL be WIDTH-bit registered outputs carrying the results.
REQ-009 busy SHALL be a 1-bit registered output, high from INIT_O through COND_O's exit to DONE.
REQ-010 done SHALL be a 1-bit registered output, high exactly while the state is DONE.

Function
REQ-011 States SHALL be IDLE, INIT_O, COND_O, INIT_I, COND_I, BODY, ITER_I, ITER_O, DONE, each lasting 1 cycle per visit.
REQ-012 IDLE SHALL go to INIT_O when start=1 and latch a/b/c/d into internal registers; otherwise it stays in IDLE.
REQ-013 INIT_O SHALL clear g, h and the outer counter oc, set i=a_latched, and go to COND_O.
REQ-014 COND_O SHALL go to INIT_I if oc<OUTER_N, else to DONE.
REQ-015 INIT_I SHALL clear the inner counter j and go to COND_I.
REQ-016 COND_I SHALL go to BODY if j<INNER_N, else to ITER_O.
REQ-017 BODY SHALL update g <= g + parity(i^j^c) and h <= h + popcount(i&b) + popcount(j&d), where parity is 1 for an odd count of ones; it then goes to ITER_I.
REQ-018 ITER_I SHALL set j <= j+1 and go to COND_I.
REQ-019 ITER_O SHALL set i <= i+1 and oc <= oc+1, then go to COND_O.
REQ-020 DONE SHALL hold while start=1 and go to IDLE when start=0.
REQ-021 g, h and i SHALL wrap modulo 2^WIDTH; j is WIDTH bits wide, zero-extended in the body expressions.
REQ-022 oc and j termination SHALL use dedicated counters sized clog2(N+1), so a wrap of i never affects the trip count.
REQ-023 done SHALL rise OUTER_N*(3*INNER_N+4)+3 clock edges after the edge at which IDLE samples start=1.
REQ-024 Operand input changes after the latch SHALL have no effect on a run in progress.
REQ-025 start changes while busy=1 SHALL be ignored.
REQ-026 g and h SHALL hold their values in DONE and IDLE until the next INIT_O.
REQ-027 A new run SHALL require start to be low for at least one cycle after done.

Reset
REQ-028 While rst=0: state=IDLE; g=h=0; busy=done=0; i, j, oc and the latched operands = 0; this is asynchronous and takes effect at any state, including mid-loop.
REQ-029 After rst rises, the first possible transition SHALL be IDLE->INIT_O at the next edge with start=1.

Structure
REQ-030 The state encoding localparams SHALL live in shared package exam_pkg.
REQ-031 A combinational sub-module bit_stats #(WIDTH) SHALL provide popcount and parity; it is instanced three times (parity term, i&b, j&d).
REQ-032 The block SHALL have one sequential process for the state register and one combinational next-state process; the datapath registers are updated in the sequential process.

Verification
REQ-033 WIDTH=8, OUTER_N=2, INNER_N=2, a=0x00, b=0x00, c=0x00, d=0xFF, start held -> done rises 23 edges after the sampling edge; g=2, h=2.
REQ-034 Same parameters, a=0xFF, b=0xFF, c=0x00, d=0x00 (i wraps FF->00) -> the run terminates with g=2, h=16, done at 23 edges.
REQ-035 OUTER_N=0 -> done rises 3 edges after the sampling edge; g=h=0; BODY is never visited.
REQ-036 rst pulsed low during BODY -> g=h=0, busy=done=0 immediately, state IDLE; a later start gives a full-length correct run.
REQ-037 Operands altered mid-run and start toggled while busy -> results are identical to REQ-033; after done, start=0 -> IDLE next edge with done=0 and g/h retained; start=1 again -> rerun with the same latency.

Source files
------------

// File: rtl/exam_pkg.sv
// Shared state encodings and sizing helper for the nested loop engine.
package exam_pkg;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_INIT_O = 4'd1;
   localparam logic [3:0] S_COND_O = 4'd2;
   localparam logic [3:0] S_INIT_I = 4'd3;
   localparam logic [3:0] S_COND_I = 4'd4;
   localparam logic [3:0] S_BODY   = 4'd5;
   localparam logic [3:0] S_ITER_I = 4'd6;
   localparam logic [3:0] S_ITER_O = 4'd7;
   localparam logic [3:0] S_DONE   = 4'd8;

   typedef enum logic [3:0] {
      IDLE   = S_IDLE,
      INIT_O = S_INIT_O,
      COND_O = S_COND_O,
      INIT_I = S_INIT_I,
      COND_I = S_COND_I,
      BODY   = S_BODY,
      ITER_I = S_ITER_I,
      ITER_O = S_ITER_O,
      DONE   = S_DONE
   } state_t;

   // Trip counters must hold the value N itself; a zero trip count still needs one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/nested_loop_engine_bit_stats.sv
// Combinational population count and odd parity of a WIDTH-bit word.
module bit_stats #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]         x,
   output logic [$clog2(WIDTH+1)-1:0] count,
   output logic                     parity
);

   localparam int CW = $clog2(WIDTH + 1);

   always_comb begin
      count = '0;
      for (int k = 0; k < WIDTH; k++) begin
         count = count + CW'(x[k]);
      end
   end

   assign parity = ^x;

endmodule

// File: rtl/nested_loop_engine.sv
// Two-level loop sequencer accumulating parity and popcount statistics over i/j.
//
// state  | meaning
// IDLE   | wait for start, latch operands
// INIT_O | clear results and outer counter, load i
// COND_O | outer trip test
// INIT_I | clear inner counter
// COND_I | inner trip test
// BODY   | accumulate g and h
// ITER_I | advance j
// ITER_O | advance i and outer counter
// DONE   | hold results until start drops
module nested_loop_engine
   import exam_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int OUTER_N = 105,
   parameter int INNER_N = 101
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             start,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] h,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int OW = cnt_width(OUTER_N);
   localparam int IW = cnt_width(INNER_N);

   state_t state, state_next;

   logic [WIDTH-1:0] a_l, b_l, c_l, d_l;
   logic [WIDTH-1:0] i;
   logic [IW-1:0]    j;
   logic [OW-1:0]    oc;
   logic [WIDTH-1:0] j_ext;

   logic [CW-1:0] par_cnt, ib_cnt, jd_cnt;
   logic          par_bit, ib_par, jd_par;
   logic          unused_stats;

   assign j_ext = WIDTH'(j);

   bit_stats #(.WIDTH(WIDTH)) u_par (.x(i ^ j_ext ^ c_l), .count(par_cnt), .parity(par_bit));
   bit_stats #(.WIDTH(WIDTH)) u_ib  (.x(i & b_l),         .count(ib_cnt),  .parity(ib_par));
   bit_stats #(.WIDTH(WIDTH)) u_jd  (.x(j_ext & d_l),     .count(jd_cnt),  .parity(jd_par));

   assign unused_stats = ^{par_cnt, ib_par, jd_par};

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = INIT_O;
         INIT_O:  state_next = COND_O;
         COND_O:  state_next = (oc < OW'(OUTER_N)) ? INIT_I : DONE;
         INIT_I:  state_next = COND_I;
         COND_I:  state_next = (j < IW'(INNER_N)) ? BODY : ITER_O;
         BODY:    state_next = ITER_I;
         ITER_I:  state_next = COND_I;
         ITER_O:  state_next = COND_O;
         DONE:    if (!start) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Flags are derived from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         g     <= '0;
         h     <= '0;
         i     <= '0;
         j     <= '0;
         oc    <= '0;
         a_l   <= '0;
         b_l   <= '0;
         c_l   <= '0;
         d_l   <= '0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE) && (state_next != DONE);
         done  <= (state_next == DONE);
         case (state)
            IDLE: if (start) begin
               a_l <= a;
               b_l <= b;
               c_l <= c;
               d_l <= d;
            end
            INIT_O: begin
               g  <= '0;
               h  <= '0;
               oc <= '0;
               i  <= a_l;
            end
            INIT_I: j <= '0;
            BODY: begin
               g <= g + WIDTH'(par_bit);
               h <= h + WIDTH'(ib_cnt) + WIDTH'(jd_cnt);
            end
            ITER_I: j <= j + 1'b1;
            ITER_O: begin
               i  <= i + 1'b1;
               oc <= oc + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nested_loop_engine.sv
// Directed bench for nested_loop_engine with a queue of expected run results.
module tb_nested_loop_engine;
   import exam_pkg::*;

   localparam int W  = 8;
   localparam int ON = 2;
   localparam int IN = 2;

   typedef struct {
      logic [W-1:0] g;
      logic [W-1:0] h;
      int           lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         start0 = 1'b0;
   logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
   logic [W-1:0] g, h, g0, h0;
   logic         busy, done, busy0, done0;

   int   checks = 0;
   int   failures = 0;
   int   body0 = 0;
   exp_t sb[$];

   nested_loop_engine #(.WIDTH(W), .OUTER_N(ON), .INNER_N(IN)) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .start(start),
      .g(g), .h(h), .busy(busy), .done(done)
   );

   nested_loop_engine #(.WIDTH(W), .OUTER_N(0), .INNER_N(IN)) dut0 (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .start(start0),
      .g(g0), .h(h0), .busy(busy0), .done(done0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (dut0.state == BODY) body0++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] na, nb, nc, nd, input int on, input int inn);
      exp_t         e;
      logic [W-1:0] iv, jv;
      e.g = '0;
      e.h = '0;
      for (int o = 0; o < on; o++) begin
         iv = na + W'(o);
         for (int jj = 0; jj < inn; jj++) begin
            jv  = W'(jj);
            e.g = e.g + W'(^(iv ^ jv ^ nc));
            e.h = e.h + W'($countones(iv & nb)) + W'($countones(jv & nd));
         end
      end
      e.lat = on * (3 * inn + 4) + 3;
      return e;
   endfunction

   // Latency counts edges from the sampling edge (edge 1) to the edge where done rises.
   task automatic run_main(input logic [W-1:0] na, nb, nc, nd, input bit disturb,
                           input string tag, output exp_t e);
      int edges;
      @(negedge clk);
      a = na; b = nb; c = nc; d = nd;
      start = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      while (!done && edges < 200) begin
         if (edges == 2) check({tag, "_busy"}, 32'(busy), 1);
         if (disturb) begin
            if (edges == 4) begin
               a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
               start = 1'b0;
            end
            if (edges == 9)  start = 1'b1;
            if (edges == 13) start = 1'b0;
            if (edges == 17) start = 1'b1;
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 0, 1);
         e = '{g: '0, h: '0, lat: 0};
      end else begin
         e = sb.pop_front();
      end
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_lat"}, 32'(edges), 32'(e.lat));
      check({tag, "_g"}, 32'(g), 32'(e.g));
      check({tag, "_h"}, 32'(h), 32'(e.h));
      check({tag, "_busy_done"}, 32'(busy), 0);
   endtask

   task automatic post_done(input string tag, input exp_t e);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold"}, 32'(done), 1);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_idle"}, 32'(dut.state == IDLE), 1);
      check({tag, "_done_low"}, 32'(done), 0);
      check({tag, "_g_keep"}, 32'(g), 32'(e.g));
      check({tag, "_h_keep"}, 32'(h), 32'(e.h));
   endtask

   initial begin
      exp_t e;
      int   edges;
      int   k;
      logic [W-1:0] ra, rb, rc, rd;

      #12;
      check("rst_g", 32'(g), 0);
      check("rst_h", 32'(h), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_state", 32'(dut.state == IDLE), 1);
      @(negedge clk);
      rst = 1'b1;

      sb.push_back('{g: 8'd2, h: 8'd2, lat: 23});
      run_main(8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "base", e);
      post_done("base", e);

      sb.push_back('{g: 8'd2, h: 8'd16, lat: 23});
      run_main(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, "wrap", e);
      post_done("wrap", e);

      sb.push_back('{g: 8'd2, h: 8'd2, lat: 23});
      run_main(8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, "disturb", e);
      post_done("disturb", e);
      sb.push_back('{g: 8'd2, h: 8'd2, lat: 23});
      run_main(8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "rerun", e);
      post_done("rerun", e);

      for (int r = 0; r < 3; r++) begin
         ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); rd = W'($urandom);
         sb.push_back(model(ra, rb, rc, rd, ON, IN));
         run_main(ra, rb, rc, rd, 1'b0, "rand", e);
         post_done("rand", e);
      end

      // Zero outer trip count on the second instance.
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      while (!done0 && edges < 50) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check("zero_done", 32'(done0), 1);
      check("zero_lat", 32'(edges), 3);
      check("zero_g", 32'(g0), 0);
      check("zero_h", 32'(h0), 0);
      check("zero_nobody", 32'(body0), 0);
      start0 = 1'b0;

      // Asynchronous reset in the middle of BODY with g already non-zero.
      @(negedge clk);
      a = 8'h00; b = 8'h00; c = 8'h01; d = 8'hFF;
      start = 1'b1;
      k = 0;
      while (!(dut.state == BODY && g != '0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("mid_reach_body", 32'(k < 100), 1);
      rst = 1'b0;
      start = 1'b0;
      #1;
      check("mid_rst_g", 32'(g), 0);
      check("mid_rst_h", 32'(h), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_state", 32'(dut.state == IDLE), 1);
      @(negedge clk);
      rst = 1'b1;
      sb.push_back(model(8'h00, 8'h00, 8'h01, 8'hFF, ON, IN));
      run_main(8'h00, 8'h00, 8'h01, 8'hFF, 1'b0, "after_rst", e);
      post_done("after_rst", e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
